nios_core_cpu_mul_seq: RTL
==========================

NIOS_CORE_CPU_MUL_SEQ -- requirements
Module: nios_core_cpu_mul_seq

Interface
REQ-001 SHALL have parameter SIGNED_EN, default 1: 1 = signed high-word ops enabled; 0 = op 2 and op 3 execute as op 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only when busy=0.
REQ-005 SHALL have port op, input, 2 bits: 0 MUL (low 32 bits), 1 MULXUU, 2 MULXSU (src1 signed, src2 unsigned), 3 MULXSS (ops 1-3 return high 32 bits).
REQ-006 SHALL have ports src1 and src2, input, 32 bits each: operands, latched on the accepting edge.
REQ-007 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after acceptance through the done cycle.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse; result is valid in that cycle.
REQ-010 SHALL have port result, output, 32 bits: registered result, held until the next accepted start.

Function
REQ-011 SHALL compute the product using exactly one 16x16 unsigned multiplier, registered with 1-cycle latency and enabled only in the ISSUE state.
REQ-012 SHALL implement the states IDLE, ISSUE, DRAIN, FIX and DONE.
REQ-013 SHALL accept a request when start=1 in IDLE at cycle T: latch src1, src2 and op; enter ISSUE; clear the 2-bit issue counter and the 64-bit accumulator.
REQ-014 SHALL spend 4 cycles in ISSUE (T+1..T+4), issuing partial products in this order: cnt0 = A_lo*B_lo, cnt1 = A_lo*B_hi, cnt2 = A_hi*B_lo, cnt3 = A_hi*B_hi.
REQ-015 SHALL add each registered product, zero-extended and shifted by 0, 16, 16 and 32 bits respectively, into the accumulator (mod 2^64) one cycle after it is issued (T+2..T+5).
REQ-016 SHALL move ISSUE to DRAIN when cnt=3; in DRAIN (T+5) it SHALL perform the final accumulate and go to FIX.
REQ-017 SHALL, in FIX (T+6), register result as follows:
- op0: acc[31:0]
- op1: acc[63:32]
- op2: acc[63:32] - (src1[31] ? src2 : 0)
- op3: acc[63:32] - (src1[31] ? src2 : 0) - (src2[31] ? src1 : 0)
- all arithmetic mod 2^32.
REQ-018 SHALL assert done=1 in DONE (T+7) and return to IDLE; busy=1 for cycles T+1..T+7 and busy=0 at T+8.
REQ-019 SHALL ignore start while busy=1; latched operands and op SHALL NOT change.
REQ-020 SHALL, on flush=1 in any non-IDLE state, go to IDLE at the next edge; no done pulse; result unchanged; busy=0 in the following cycle.
REQ-021 SHALL give flush priority over start when both are high in the same IDLE cycle; the start is dropped.
REQ-022 SHALL NOT suppress done for a flush asserted during the DONE cycle itself.
REQ-023 SHALL allow a start in the first cycle after DONE (back-to-back requests every 8 cycles).

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force: state IDLE, cnt 0, accumulator 0, multiplier register 0, busy 0, done 0, result 0x00000000.
REQ-025 SHALL, when reset is asserted mid-operation, discard the operation; no done after release.
REQ-026 SHALL accept a start on the first rising edge after reset_n deasserts.

Verification
REQ-027 SHALL cover: op0, src1=0x00010003, src2=0x00020005 -> done at T+7, result=0x000B000F; the same operands with op1 -> 0x00000002.
REQ-028 SHALL cover: op1, src1=src2=0xFFFFFFFF -> 0xFFFFFFFE; op3 with the same operands -> 0x00000000; op2 with the same operands -> 0xFFFFFFFF.
REQ-029 SHALL cover: SIGNED_EN=0, op3, src1=src2=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 SHALL cover: start at T, flush at T+3 -> no done, busy=0 at T+4, result keeps its previous value; a new start at T+4 completes normally.
REQ-031 SHALL cover: a second start with different operands at T+2 -> ignored; the first result is returned at T+7.
REQ-032 SHALL cover: reset_n pulsed low at T+4 -> outputs 0 immediately; no done; a start after release gives the correct result.

Source files
------------

// File: rtl/nios_core_cpu_mul_seq.sv
// nios_core_cpu_mul_seq
// Sequential 32x32 multiplier for the CPU core. Forms the 64-bit product from
// four 16x16 partial products through a single registered 16x16 unsigned
// multiplier. It then corrects the high word for signed operand forms.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   reset_n    : asynchronous active-low reset
//   start      : request a multiply (only looked at while idle)
//   op[1:0]    : 0 MUL (low word), 1 MULXUU, 2 MULXSU, 3 MULXSS (high word)
//   src1, src2 : operands, captured on the accepting edge
//   flush      : abort the operation in progress
//   busy       : high from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse, result valid in that cycle
//   result     : registered result, held until overwritten by a later op
//   dbg_state  : current FSM state (debug observation only)
//
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// the block is idle (busy=0). Exactly one done pulse follows 7 cycles later
// unless flush or reset intervenes. There is no backpressure on done.
module nios_core_cpu_mul_seq #(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [31:0] mul_q;
    logic [63:0] acc;

    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_prod;
    logic [63:0] addend;
    logic [63:0] acc_next;
    logic [1:0]  eff_op;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] fix_val;

    assign dbg_state = state;

    // Issue order: cnt0 lo*lo, cnt1 lo*hi, cnt2 hi*lo, cnt3 hi*hi.
    assign mul_a    = cnt[1] ? a_q[31:16] : a_q[15:0];
    assign mul_b    = cnt[0] ? b_q[31:16] : b_q[15:0];
    assign mul_prod = mul_a * mul_b;

    // mul_q holds the product issued one cycle earlier, so the shift is
    // chosen by the previous count value (cnt-1), and DRAIN adds hi*hi.
    always_comb begin
        addend = 64'd0;
        if (state == S_ISSUE) begin
            case (cnt)
                2'd1:    addend = {32'd0, mul_q};
                2'd2:    addend = {16'd0, mul_q, 16'd0};
                2'd3:    addend = {16'd0, mul_q, 16'd0};
                default: addend = 64'd0;
            endcase
        end else if (state == S_DRAIN) begin
            addend = {mul_q, 32'd0};
        end
    end

    assign acc_next = acc + addend;

    // Without signed support the signed ops collapse to the unsigned high word.
    assign eff_op = (!SIGNED_EN && op_q[1]) ? 2'd1 : op_q;

    // Signed high word = unsigned high word minus src2 when src1 is negative
    // and (for SS) minus src1 when src2 is negative; all mod 2^32.
    assign corr_a  = (eff_op[1] && a_q[31]) ? b_q : 32'd0;
    assign corr_b  = (eff_op == 2'd3 && b_q[31]) ? a_q : 32'd0;
    assign fix_val = (eff_op == 2'd0) ? acc[31:0]
                                      : (acc[63:32] - corr_a - corr_b);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= 2'd0;
            mul_q  <= 32'd0;
            acc    <= 64'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
        end else if (state != S_IDLE && flush) begin
            // A flush during DONE still lets the pulse already on done stand.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        a_q   <= src1;
                        b_q   <= src2;
                        op_q  <= op;
                        cnt   <= 2'd0;
                        acc   <= 64'd0;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_q <= mul_prod;
                    acc   <= acc_next;
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    acc   <= acc_next;
                    state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
